register_file_sb: RTL and testbench

Parametrised successor to the single-cycle CPU register file, for the pipelined core. It provides two asynchronous read ports and one synchronous write port, with optional same-cycle write-to-read bypass. A per-register pending-write scoreboard with an issue handshake lets the hazard unit stall on in-flight producers. A generalised, registered halt detector replaces the hard-wired x17 == 10 ecall check.

---
 rtl/register_file_sb_pkg.sv | 15 +
 rtl/register_file_sb_if.sv | 38 +++
 rtl/register_file_sb_scoreboard.sv | 70 +++++++
 rtl/register_file_sb.sv | 83 ++++++++
 tb/tb_register_file_sb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared constants for the pipelined register file: default sizes, the
// architectural register indices it treats specially and their reset/halt values.
package rf_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;

    localparam int REG_ZERO = 0;   // hard-wired zero register
    localparam int REG_SP   = 2;   // stack pointer
    localparam int REG_A7   = 17;  // ecall service number

    localparam int          ECALL_EXIT = 10;
    localparam logic [31:0] SP_RESET   = 32'h0000_2ffc;

endpackage

// File: rtl/register_file_sb_if.sv
// Register file bus: two read ports, an issue port into the scoreboard and
// one writeback port.
//
// Issue handshake: a producer for issue_rd is accepted at a posedge where
// issue_valid && issue_ready are both high. When issue_ready is low the
// issue has no effect and the issuer must keep issue_valid (and issue_rd)
// stable until it is accepted. Writeback (write_enable) has no back-pressure.
interface register_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rs1_dout;
    logic [XLEN-1:0] rs2_dout;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_din;
    logic            write_enable;
    logic            halt;
    logic            wb_underflow;

    // Core side: drives indices, issue and writeback.
    modport master (
        output rs1, rs2, issue_valid, issue_rd, rd, rd_din, write_enable,
        input  rs1_dout, rs2_dout, rs1_busy, rs2_busy, issue_ready, halt, wb_underflow
    );

    // Register file side.
    modport slave (
        input  rs1, rs2, issue_valid, issue_rd, rd, rd_din, write_enable,
        output rs1_dout, rs2_dout, rs1_busy, rs2_busy, issue_ready, halt, wb_underflow
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: one saturating in-flight counter per register,
// incremented by accepted issues and decremented by writebacks. Produces the
// issue back-pressure, the per-read-port busy flags and a sticky underflow flag.
module rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid_i,
    input  logic [AW-1:0] issue_rd_i,
    output logic          issue_ready_o,
    input  logic          write_enable_i,
    input  logic [AW-1:0] rd_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          wb_underflow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               BYP     = (BYPASS != 0);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             underflow_q;
    logic             underflow_d;
    logic             inc;
    logic             dec;

    // Index 0 is never tracked, so it is always ready and never busy.
    assign issue_ready_o = (issue_rd_i == '0) || (cnt_q[issue_rd_i] != CNT_MAX);

    // A counter at 1 that is being retired this cycle only reads as free when
    // the writeback data is forwarded to the same-cycle read.
    assign rs1_busy_o = (rs1_i != '0) &&
                        ((cnt_q[rs1_i] > CNT_ONE) ||
                         ((cnt_q[rs1_i] == CNT_ONE) && !(BYP && write_enable_i && (rd_i == rs1_i))));
    assign rs2_busy_o = (rs2_i != '0) &&
                        ((cnt_q[rs2_i] > CNT_ONE) ||
                         ((cnt_q[rs2_i] == CNT_ONE) && !(BYP && write_enable_i && (rd_i == rs2_i))));

    assign wb_underflow_o = underflow_q;

    // Next counter values: inc then dec, so a simultaneous pair on one register cancels.
    always_comb begin
        cnt_d       = cnt_q;
        inc         = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
        dec         = write_enable_i && (rd_i != '0) && (cnt_q[rd_i] != '0);
        underflow_d = underflow_q || (write_enable_i && (rd_i != '0) && (cnt_q[rd_i] == '0));
        if (inc) cnt_d[issue_rd_i] = cnt_q[issue_rd_i] + CNT_ONE;
        if (dec) cnt_d[rd_i]       = cnt_d[rd_i] - CNT_ONE;
    end

    // Counter and sticky-flag state; reset discards all in-flight counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '{default: '0};
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/register_file_sb.sv
// Pipelined-core register file: two asynchronous read ports with optional
// writeback bypass, one synchronous write port, a pending-write scoreboard and
// a registered halt detector on a configurable register/value pair.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              NUM_REGS = NUM_REGS_DEF,
    parameter int              CNT_W    = 2,
    parameter int              BYPASS   = 1,
    parameter int              SP_IDX   = REG_SP,
    parameter logic [XLEN-1:0] SP_INIT  = XLEN'(SP_RESET),
    parameter int              HALT_IDX = REG_A7,
    parameter int              HALT_VAL = ECALL_EXIT,
    localparam int             AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    register_file_sb_if.slave    bus
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
    localparam bit            BYP      = (BYPASS != 0);

    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic            halt_q;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Storage: reset clears everything except the stack pointer; x0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            rf_q[SP_IDX] <= SP_INIT;
        end else if (bus.write_enable && (bus.rd != ZERO_IDX)) begin
            rf_q[bus.rd] <= bus.rd_din;
        end
    end

    // Halt looks at stored contents only, so it trails a write by one edge.
    always_ff @(posedge clk) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= (rf_q[HALT_IDX] == XLEN'(HALT_VAL));
    end

    // Read port 1: zero register, then same-cycle forwarding, then storage.
    always_comb begin
        rs1_data = rf_q[bus.rs1];
        if (bus.rs1 == ZERO_IDX)                                     rs1_data = '0;
        else if (BYP && bus.write_enable && (bus.rd == bus.rs1))     rs1_data = bus.rd_din;
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rs2_data = rf_q[bus.rs2];
        if (bus.rs2 == ZERO_IDX)                                     rs2_data = '0;
        else if (BYP && bus.write_enable && (bus.rd == bus.rs2))     rs2_data = bus.rd_din;
    end

    assign bus.rs1_dout = rs1_data;
    assign bus.rs2_dout = rs2_data;
    assign bus.halt     = halt_q;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .issue_valid_i  (bus.issue_valid),
        .issue_rd_i     (bus.issue_rd),
        .issue_ready_o  (bus.issue_ready),
        .write_enable_i (bus.write_enable),
        .rd_i           (bus.rd),
        .rs1_i          (bus.rs1),
        .rs2_i          (bus.rs2),
        .rs1_busy_o     (bus.rs1_busy),
        .rs2_busy_o     (bus.rs2_busy),
        .wb_underflow_o (bus.wb_underflow)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: a forwarding (BYPASS=1) and a non-forwarding
// (BYPASS=0) instance share one stimulus stream and are checked against an
// array-based model of registers, in-flight counts, halt and underflow.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, issue_rd, rd;
    logic        issue_valid, write_enable;
    logic [31:0] rd_din;

    logic [31:0] m_rf  [32];
    int          m_cnt [32];
    logic        m_uf;
    logic        m_halt;

    int n_checks = 0;
    int n_pass   = 0;

    register_file_sb_if #(.XLEN(32), .AW(5)) bus1 ();
    register_file_sb_if #(.XLEN(32), .AW(5)) bus0 ();

    assign bus1.rs1 = rs1;          assign bus0.rs1 = rs1;
    assign bus1.rs2 = rs2;          assign bus0.rs2 = rs2;
    assign bus1.issue_valid = issue_valid;  assign bus0.issue_valid = issue_valid;
    assign bus1.issue_rd = issue_rd;        assign bus0.issue_rd = issue_rd;
    assign bus1.rd = rd;            assign bus0.rd = rd;
    assign bus1.rd_din = rd_din;    assign bus0.rd_din = rd_din;
    assign bus1.write_enable = write_enable; assign bus0.write_enable = write_enable;

    register_file_sb #(.BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    register_file_sb #(.BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_dout(input logic [4:0] idx, input bit byp);
        if (idx == 0) return 32'h0;
        if (byp && write_enable && rd == idx) return rd_din;
        return m_rf[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx, input bit byp);
        bool_retire: begin end
        if (idx == 0) return 1'b0;
        if (m_cnt[idx] >= 2) return 1'b1;
        if (m_cnt[idx] == 1) return !(byp && write_enable && rd == idx);
        return 1'b0;
    endfunction

    function automatic logic exp_ready();
        return (issue_rd == 0) || (m_cnt[issue_rd] < 3);
    endfunction

    task automatic model_update();
        logic rdy;
        logic nh;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_rf[i] = 32'h0; m_cnt[i] = 0; end
            m_rf[2] = 32'h2ffc;
            m_uf    = 1'b0;
            m_halt  = 1'b0;
        end else begin
            rdy = exp_ready();
            nh  = (m_rf[17] == 32'd10);
            if (write_enable && rd != 0) begin
                if (m_cnt[rd] == 0) m_uf = 1'b1;
                else                m_cnt[rd] = m_cnt[rd] - 1;
            end
            if (issue_valid && rdy && issue_rd != 0) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
            if (write_enable && rd != 0) m_rf[rd] = rd_din;
            m_halt = nh;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        reset = 1'b0; issue_valid = 1'b0; write_enable = 1'b0;
        issue_rd = 5'd0; rd = 5'd0; rd_din = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] e;
        idle(); reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i); #1;
            e = (i == 2) ? 32'h2ffc : 32'h0;
            n_checks++;
            if ({bus1.rs1_dout, bus0.rs1_dout} !== {e, e})
                $display("FAIL reset_read x%0d: got %h/%h exp %h", i, bus1.rs1_dout, bus0.rs1_dout, e);
            else n_pass++;
        end
        n_checks++;
        if ({bus1.rs1_busy, bus1.rs2_busy, bus1.halt, bus1.wb_underflow,
             bus0.rs1_busy, bus0.rs2_busy, bus0.halt, bus0.wb_underflow} !== 8'h00)
            $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b exp 00000000",
                     bus1.rs1_busy, bus1.rs2_busy, bus1.halt, bus1.wb_underflow,
                     bus0.rs1_busy, bus0.rs2_busy, bus0.halt, bus0.wb_underflow);
        else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); write_enable = 1'b1; rd = 5'd5; rd_din = 32'hDEADBEEF; rs1 = 5'd5; #1;
        n_checks++;
        if (bus1.rs1_dout !== 32'hDEADBEEF) $display("FAIL bypass_on: got %h exp deadbeef", bus1.rs1_dout);
        else n_pass++;
        n_checks++;
        if (bus0.rs1_dout !== 32'h0) $display("FAIL bypass_off_old: got %h exp 00000000", bus0.rs1_dout);
        else n_pass++;
        tick(); idle(); rs1 = 5'd5; #1;
        n_checks++;
        if ({bus1.rs1_dout, bus0.rs1_dout} !== {32'hDEADBEEF, 32'hDEADBEEF})
            $display("FAIL bypass_next: got %h/%h exp deadbeef", bus1.rs1_dout, bus0.rs1_dout);
        else n_pass++;
    endtask

    task automatic test_saturate();
        idle(); reset = 1'b1; tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus1.issue_ready !== 1'b1) $display("FAIL issue_ready_%0d: got %b exp 1", k, bus1.issue_ready);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bus1.issue_ready, bus0.issue_ready} !== 2'b00)
            $display("FAIL issue_saturated: got %b%b exp 00", bus1.issue_ready, bus0.issue_ready);
        else n_pass++;
        tick();  // fourth issue held against a full counter
        idle(); rs1 = 5'd7; write_enable = 1'b1; rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            rd_din = 32'h100 + 32'(k); #1;
            n_checks++;
            if ({bus1.rs1_busy, bus0.rs1_busy} !== {(k != 2), 1'b1})
                $display("FAIL busy_wb%0d: got %b%b exp %b1", k, bus1.rs1_busy, bus0.rs1_busy, (k != 2));
            else n_pass++;
            tick();
        end
        idle(); rs1 = 5'd7; #1;
        n_checks++;
        if ({bus1.rs1_busy, bus0.rs1_busy, bus1.wb_underflow} !== 3'b000)
            $display("FAIL busy_drained: got %b%b uf %b exp 000", bus1.rs1_busy, bus0.rs1_busy, bus1.wb_underflow);
        else n_pass++;
    endtask

    task automatic test_issue_wb_same();
        idle(); issue_valid = 1'b1; issue_rd = 5'd9; tick();
        issue_valid = 1'b1; issue_rd = 5'd9; write_enable = 1'b1; rd = 5'd9; rd_din = 32'h99; rs2 = 5'd9; #1;
        n_checks++;
        if ({bus1.rs2_busy, bus0.rs2_busy} !== 2'b01)
            $display("FAIL same_cycle_busy: got %b%b exp 01", bus1.rs2_busy, bus0.rs2_busy);
        else n_pass++;
        tick(); idle(); rs2 = 5'd9; #1;
        n_checks++;
        if ({bus1.rs2_busy, bus0.rs2_busy} !== 2'b11)
            $display("FAIL same_cycle_cnt_kept: got %b%b exp 11", bus1.rs2_busy, bus0.rs2_busy);
        else n_pass++;
        write_enable = 1'b1; rd = 5'd9; rd_din = 32'h9a; tick(); idle();
    endtask

    task automatic test_halt();
        idle(); write_enable = 1'b1; rd = 5'd17; rd_din = 32'd10; tick(); idle(); #1;
        n_checks++;
        if ({bus1.halt, bus0.halt} !== 2'b00) $display("FAIL halt_edgeN: got %b%b exp 00", bus1.halt, bus0.halt);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus1.halt, bus0.halt} !== 2'b11) $display("FAIL halt_edgeN1: got %b%b exp 11", bus1.halt, bus0.halt);
        else n_pass++;
        write_enable = 1'b1; rd = 5'd17; rd_din = 32'd0; tick(); idle();
        n_checks++;
        if (bus1.halt !== 1'b1) $display("FAIL halt_overwrite_edge: got %b exp 1", bus1.halt);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus1.halt, bus0.halt} !== 2'b00) $display("FAIL halt_dropped: got %b%b exp 00", bus1.halt, bus0.halt);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle(); write_enable = 1'b1; rd = 5'd0; rd_din = 32'h1234; issue_valid = 1'b1; issue_rd = 5'd0; #1;
        n_checks++;
        if ({bus1.rs1_dout, bus1.issue_ready, bus1.rs1_busy} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL x0_write_cycle: got %h rdy %b busy %b exp 0 1 0", bus1.rs1_dout, bus1.issue_ready, bus1.rs1_busy);
        else n_pass++;
        tick(); idle(); #1;
        n_checks++;
        if ({bus1.rs1_dout, bus0.rs1_dout, bus1.rs1_busy} !== {64'h0, 1'b0})
            $display("FAIL x0_read: got %h/%h busy %b exp 0", bus1.rs1_dout, bus0.rs1_dout, bus1.rs1_busy);
        else n_pass++;
    endtask

    task automatic test_underflow();
        idle(); reset = 1'b1; tick(); idle();
        write_enable = 1'b1; rd = 5'd3; rd_din = 32'h55; tick(); idle(); rs1 = 5'd3; #1;
        n_checks++;
        if ({bus1.rs1_dout, bus0.rs1_dout, bus1.wb_underflow, bus0.wb_underflow} !== {32'h55, 32'h55, 2'b11})
            $display("FAIL underflow_set: got %h/%h uf %b%b exp 55 11", bus1.rs1_dout, bus0.rs1_dout, bus1.wb_underflow, bus0.wb_underflow);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (bus1.wb_underflow !== 1'b1) $display("FAIL underflow_sticky: got %b exp 1", bus1.wb_underflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle(); issue_valid = 1'b1; issue_rd = 5'd4; tick(); tick();
        issue_rd = 5'd6; tick(); idle(); rs1 = 5'd4; rs2 = 5'd6; #1;
        n_checks++;
        if ({bus1.rs1_busy, bus1.rs2_busy} !== 2'b11) $display("FAIL pending_before_reset: got %b%b exp 11", bus1.rs1_busy, bus1.rs2_busy);
        else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0; #1;
        n_checks++;
        if ({bus1.rs1_busy, bus1.rs2_busy, bus0.rs1_busy, bus0.rs2_busy, bus1.wb_underflow} !== 5'b00000)
            $display("FAIL reset_mid_flags: got %b%b%b%b uf %b exp 00000", bus1.rs1_busy, bus1.rs2_busy, bus0.rs1_busy, bus0.rs2_busy, bus1.wb_underflow);
        else n_pass++;
        rs1 = 5'd2; #1;
        n_checks++;
        if (bus1.rs1_dout !== 32'h2ffc) $display("FAIL reset_mid_sp: got %h exp 00002ffc", bus1.rs1_dout);
        else n_pass++;
        write_enable = 1'b1; rd = 5'd4; rd_din = 32'h77; tick(); idle(); rs1 = 5'd4; #1;
        n_checks++;
        if ({bus1.wb_underflow, bus1.rs1_dout} !== {1'b1, 32'h77})
            $display("FAIL late_writeback: got uf %b data %h exp 1 77", bus1.wb_underflow, bus1.rs1_dout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [68:0] got1, exp1, got0, exp0;
        idle(); reset = 1'b1; tick();
        for (int c = 0; c < 600; c++) begin
            reset        = ($urandom_range(0, 63) == 0);
            issue_valid  = $urandom_range(0, 1);
            issue_rd     = 5'($urandom_range(0, 7));
            write_enable = ($urandom_range(0, 9) < 4);
            rd           = 5'($urandom_range(0, 7));
            rd_din       = ($urandom_range(0, 7) == 0) ? 32'd10 : $urandom;
            if ($urandom_range(0, 3) == 0) rd = 5'd17;
            rs1          = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom_range(0, 7));
            rs2          = 5'($urandom_range(0, 31));
            #1;
            got1 = {bus1.rs1_dout, bus1.rs2_dout, bus1.rs1_busy, bus1.rs2_busy, bus1.issue_ready, bus1.halt, bus1.wb_underflow};
            exp1 = {exp_dout(rs1, 1), exp_dout(rs2, 1), exp_busy(rs1, 1), exp_busy(rs2, 1), exp_ready(), m_halt, m_uf};
            got0 = {bus0.rs1_dout, bus0.rs2_dout, bus0.rs1_busy, bus0.rs2_busy, bus0.issue_ready, bus0.halt, bus0.wb_underflow};
            exp0 = {exp_dout(rs1, 0), exp_dout(rs2, 0), exp_busy(rs1, 0), exp_busy(rs2, 0), exp_ready(), m_halt, m_uf};
            n_checks++;
            if (got1 !== exp1) $display("FAIL random_byp1 cycle %0d: got %h exp %h", c, got1, exp1);
            else n_pass++;
            n_checks++;
            if (got0 !== exp0) $display("FAIL random_byp0 cycle %0d: got %h exp %h", c, got0, exp0);
            else n_pass++;
            tick();
        end
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_bypass();
        test_saturate();
        test_issue_wb_same();
        test_halt();
        test_x0();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
